// File: rtl/if_id_fetch_reg_pkg.sv
// rtl/if_id_fetch_reg_pkg.sv - shared widths, NOP encoding and fetch FSM states
package if_id_fetch_reg_pkg;

    localparam int PC_W    = 6;
    localparam int INSTR_W = 32;
    localparam int AW      = PC_W - 2;
    localparam int DEPTH   = 2 ** AW;

    localparam logic [INSTR_W-1:0] NOP = '0;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Word index of a byte-addressed PC.
    function automatic logic [AW-1:0] word_idx(input logic [PC_W-1:0] pc);
        return pc[PC_W-1:2];
    endfunction

endpackage

// File: rtl/if_id_fetch_reg_if.sv
// rtl/if_id_fetch_reg_if.sv - PC/loader side to IF/ID register bundle
interface if_id_fetch_reg_if;
    import if_id_fetch_reg_pkg::*;

    logic [PC_W-1:0]    pc_curr;
    logic               stall;
    logic               jump_cs;
    logic               load_en;
    logic [AW-1:0]      load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               load_done;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    pc_out;
    logic               valid_out;
    logic               state_run;
    logic               misalign_err;
    logic               load_err;

    // Program counter / loader side.
    modport master (
        output pc_curr, stall, jump_cs, load_en, load_addr, load_data, load_done,
        input  instr_out, pc_out, valid_out, state_run, misalign_err, load_err
    );

    // Fetch register side.
    modport slave (
        input  pc_curr, stall, jump_cs, load_en, load_addr, load_data, load_done,
        output instr_out, pc_out, valid_out, state_run, misalign_err, load_err
    );

endinterface

// File: rtl/if_id_fetch_reg_instr_mem.sv
// rtl/if_id_fetch_reg_instr_mem.sv - instruction array, synchronous write, asynchronous read
module if_id_fetch_reg_instr_mem
    import if_id_fetch_reg_pkg::*;
(
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    // Contents survive reset so an image can be reused after a restart.
    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Loader write at the clock edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_fetch_reg.sv
// rtl/if_id_fetch_reg.sv - instruction fetch into the IF/ID pipeline register
module if_id_fetch_reg
    import if_id_fetch_reg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    if_id_fetch_reg_if.slave bus
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;
    logic               misalign_q, misalign_d;
    logic               load_err_q, load_err_d;

    logic               mem_we;
    logic [INSTR_W-1:0] mem_rdata;

    // Writes are only honoured while the image is being loaded.
    assign mem_we = (state_q == ST_LOAD) && bus.load_en;

    if_id_fetch_reg_instr_mem u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (bus.load_addr),
        .wdata_i (bus.load_data),
        .raddr_i (word_idx(bus.pc_curr)),
        .rdata_o (mem_rdata)
    );

    // Next state: flush beats stall, stall beats misalign check, else fetch.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        load_err_d = load_err_q;
        case (state_q)
            ST_LOAD: begin
                if (bus.load_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.load_en) begin
                    load_err_d = 1'b1;
                end
                if (bus.jump_cs) begin
                    instr_d = NOP;
                    valid_d = 1'b0;
                    pc_d    = bus.pc_curr;
                end else if (!bus.stall) begin
                    pc_d = bus.pc_curr;
                    if (bus.pc_curr[1:0] != 2'b00) begin
                        instr_d    = NOP;
                        valid_d    = 1'b0;
                        misalign_d = 1'b1;
                    end else begin
                        instr_d = mem_rdata;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // FSM and IF/ID register; reset returns to LOAD with a bubble in IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            instr_q    <= NOP;
            pc_q       <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.instr_out    = instr_q;
    assign bus.pc_out       = pc_q;
    assign bus.valid_out    = valid_q;
    assign bus.state_run    = (state_q == ST_RUN);
    assign bus.misalign_err = misalign_q;
    assign bus.load_err     = load_err_q;

endmodule
